// File: rtl/dbg_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_uart_pkg
//  Description : Shared types and constants for the debug-print UART
//                transmitter: transmitter state encoding, bit-time divisor
//                helper and frame length.
//  Revision    : 1.0 - initial release
// ============================================================================
package dbg_uart_pkg;

    // Transmitter line states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // 8N1 frame: start + 8 data + stop.
    localparam int FRAME_BITS = 10;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Synchronous show-ahead FIFO. dout_o presents the head entry
//                whenever empty_o is low; pop_i consumes it.
//  Ports       : clk, rstn      - clock, async active-low reset
//                push_i, din_i  - write strobe and data (ignored when full)
//                pop_i, dout_o  - read strobe (ignored when empty), head data
//                count_o        - occupancy 0..DEPTH
//                full_o/empty_o - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage needs no reset; only the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the separate
    // count disambiguates full from empty when the pointers are equal.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Buffered 8N1 UART transmitter. Bytes enter through a
//                valid/ready handshake into a byte FIFO and are shifted out
//                LSB first on a registered, idle-high txd line.
//  Ports       : clk, rstn        - clock, async active-low reset
//                d_tx, vld_tx     - byte and its valid strobe
//                rdy_tx           - FIFO has room
//                txd              - serial line
//                busy             - FIFO non-empty or frame in flight
//                fifo_cnt         - FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import dbg_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [7:0]                    d_tx,
    input  logic                          vld_tx,
    output logic                          rdy_tx,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int DIV      = calc_div(CLK_FREQ, BAUD);
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LAST_BIT = FRAME_BITS - 3;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    tx_state_e                    state_q;
    logic [DIV_W-1:0]             baud_cnt_q;
    logic [2:0]                   bit_idx_q;
    logic [7:0]                   shift_q;
    logic                         txd_q;

    logic [7:0]                   fifo_dout;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         push;
    logic                         pop;
    logic                         baud_end;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .din_i   (d_tx),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rdy_tx   = !fifo_full;
    assign push     = vld_tx && rdy_tx;
    assign fifo_cnt = fifo_count;
    assign txd      = txd_q;
    assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);
    assign baud_end = (baud_cnt_q == DIV_LAST);

    // A byte is fetched either from idle or on the last clock of a stop bit,
    // so consecutive frames follow with no idle gap.
    assign pop = !fifo_empty &&
                 ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_end));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
        end else if (pop) begin
            shift_q    <= fifo_dout;
            baud_cnt_q <= '0;
            txd_q      <= 1'b0;
            state_q    <= ST_START;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    txd_q      <= 1'b1;
                    baud_cnt_q <= '0;
                end
                ST_START: begin
                    if (baud_end) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        txd_q      <= shift_q[0];
                        state_q    <= ST_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 3'(LAST_BIT)) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            // Next bit is driven straight from shift_q[1]
                            // so txd stays a pure register output.
                            shift_q   <= {1'b0, shift_q[7:1]};
                            txd_q     <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt_q <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo with DIV=16, depth 4.
//                A serial monitor decodes frames from txd; decoded bytes are
//                compared against a queue of accepted bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;
    localparam int BIT_T = 16;
    localparam int FRAME_T = 10 * BIT_T;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] d_tx = 8'h00;
    logic       vld_tx = 1'b0;
    logic       rdy_tx;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_cnt;

    uart_tx_fifo #(
        .CLK_FREQ   (16),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .d_tx     (d_tx),
        .vld_tx   (vld_tx),
        .rdy_tx   (rdy_tx),
        .txd      (txd),
        .busy     (busy),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- serial monitor (sole writer of rx_*) ----------------
    int         cyc = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte [64];
    int         rx_start [64];
    bit         rx_bad [64];
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    int         mon_b = 0;
    int         mon_t0 = 0;
    logic [7:0] mon_sh = 8'h00;
    bit         mon_bad = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rstn) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (txd === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                mon_t0  = cyc;
                mon_bad = 1'b0;
            end
        end else begin
            mon_cnt = mon_cnt + 1;
            if (mon_cnt % BIT_T == BIT_T / 2) begin
                mon_b = mon_cnt / BIT_T;
                if (mon_b == 0) begin
                    if (txd !== 1'b0) mon_bad = 1'b1;
                end else if (mon_b <= 8) begin
                    mon_sh[mon_b-1] = txd;
                end else begin
                    if (txd !== 1'b1) mon_bad = 1'b1;
                    if (rx_cnt < 64) begin
                        rx_byte[rx_cnt]  = mon_sh;
                        rx_start[rx_cnt] = mon_t0;
                        rx_bad[rx_cnt]   = mon_bad;
                        rx_cnt = rx_cnt + 1;
                    end
                    mon_act = 1'b0;
                end
            end
        end
    end

    // ---------------- checking infrastructure ----------------
    int         n_cmp = 0;
    int         n_err = 0;
    int         tcount = 0;
    int         rd_idx = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        int         t;
        logic       txd;
        logic       busy;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp = n_cmp + 1;
        n_err = n_err + 1;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    task automatic tick();
        @(negedge clk);
        tcount = tcount + 1;
    endtask

    // Present a byte at a negedge and hold it until ready; acc returns the
    // negedge index preceding the accepting rising edge.
    task automatic send(input logic [7:0] b, output int acc, inout int peak);
        int w;
        w = 0;
        acc = -1;
        d_tx   = b;
        vld_tx = 1'b1;
        while (w < 3000) begin
            if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
            chk("rdy_vs_full", {31'd0, rdy_tx}, {31'd0, (fifo_cnt != 3'(DEPTH))});
            if (rdy_tx) begin
                acc = tcount;
                exp_q.push_back(b);
                tick();
                vld_tx = 1'b0;
                return;
            end
            tick();
            w = w + 1;
        end
        vld_tx = 1'b0;
        fail_now("send_accept");
    endtask

    task automatic drain(input int n, input bit spaced);
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (rx_cnt <= rd_idx && w < 3000) begin
                tick();
                w = w + 1;
            end
            if (rx_cnt <= rd_idx) begin
                fail_now("rx_frame");
                return;
            end
            if (exp_q.size() == 0) begin
                n_cmp = n_cmp + 1;
                n_err = n_err + 1;
                $display("FAIL rx_extra: got 0x%0h expected no frame", rx_byte[rd_idx]);
            end else begin
                chk("rx_byte", {24'd0, rx_byte[rd_idx]}, {24'd0, exp_q.pop_front()});
            end
            chk("rx_framing", {31'd0, rx_bad[rd_idx]}, 32'd0);
            if (spaced && i > 0) begin
                chk("frame_spacing", rx_start[rd_idx] - rx_start[rd_idx-1], FRAME_T);
            end
            rd_idx = rd_idx + 1;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 3000) begin
            tick();
            w = w + 1;
        end
        if (busy) fail_now("wait_idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int         t_now;
        int         acc [12];
        int         peak;
        int         t0;
        int         snap;
        bit         saw_low;
        logic [7:0] burst [6];

        // Single-frame waveform for 0x41, t counted from the edge after push.
        tbl[0]  = '{0,   1'b0, 1'b1, 3'd0};
        tbl[1]  = '{8,   1'b0, 1'b1, 3'd0};
        tbl[2]  = '{15,  1'b0, 1'b1, 3'd0};
        tbl[3]  = '{16,  1'b1, 1'b1, 3'd0};
        tbl[4]  = '{31,  1'b1, 1'b1, 3'd0};
        tbl[5]  = '{32,  1'b0, 1'b1, 3'd0};
        tbl[6]  = '{100, 1'b0, 1'b1, 3'd0};
        tbl[7]  = '{111, 1'b0, 1'b1, 3'd0};
        tbl[8]  = '{112, 1'b1, 1'b1, 3'd0};
        tbl[9]  = '{127, 1'b1, 1'b1, 3'd0};
        tbl[10] = '{128, 1'b0, 1'b1, 3'd0};
        tbl[11] = '{143, 1'b0, 1'b1, 3'd0};
        tbl[12] = '{144, 1'b1, 1'b1, 3'd0};
        tbl[13] = '{159, 1'b1, 1'b1, 3'd0};
        tbl[14] = '{160, 1'b1, 1'b0, 3'd0};
        tbl[15] = '{175, 1'b1, 1'b0, 3'd0};

        burst[0] = 8'h50; burst[1] = 8'h43; burst[2] = 8'h3D;
        burst[3] = 8'h30; burst[4] = 8'h0D; burst[5] = 8'h0A;
        peak = 0;

        // Reset values
        rstn = 1'b0;
        tick(); tick(); tick();
        chk("rst_txd",  {31'd0, txd},    32'd1);
        chk("rst_rdy",  {31'd0, rdy_tx}, 32'd1);
        chk("rst_busy", {31'd0, busy},   32'd0);
        chk("rst_cnt",  {29'd0, fifo_cnt}, 32'd0);
        rstn = 1'b1;
        tick(); tick();

        // Single byte 0x41
        d_tx = 8'h41;
        vld_tx = 1'b1;
        chk("t1_rdy", {31'd0, rdy_tx}, 32'd1);
        exp_q.push_back(8'h41);
        tick();
        vld_tx = 1'b0;
        chk("t1_txd_k",  {31'd0, txd},  32'd1);
        chk("t1_cnt_k",  {29'd0, fifo_cnt}, 32'd1);
        chk("t1_busy_k", {31'd0, busy}, 32'd1);
        tick();
        t_now = 0;
        for (int i = 0; i < 16; i++) begin
            while (t_now < tbl[i].t) begin
                tick();
                t_now = t_now + 1;
            end
            chk($sformatf("t1_txd[%0d]", tbl[i].t),  {31'd0, txd},  {31'd0, tbl[i].txd});
            chk($sformatf("t1_busy[%0d]", tbl[i].t), {31'd0, busy}, {31'd0, tbl[i].busy});
            chk($sformatf("t1_cnt[%0d]", tbl[i].t),  {29'd0, fifo_cnt}, {29'd0, tbl[i].cnt});
        end
        drain(1, 1'b0);

        // Burst into a full FIFO
        wait_idle();
        peak = 0;
        for (int i = 0; i < 6; i++) send(burst[i], acc[i], peak);
        for (int i = 1; i < 5; i++) chk($sformatf("burst_acc[%0d]", i), acc[i] - acc[0], i);
        chk("burst_wait_acc", acc[5] - acc[0], FRAME_T + 2);
        chk("burst_peak", peak, DEPTH);
        drain(6, 1'b1);

        // Push coinciding with the STOP->START pop at count 2
        wait_idle();
        peak = 0;
        send(8'h61, acc[0], peak);
        send(8'h62, acc[1], peak);
        send(8'h63, acc[2], peak);
        t0 = acc[0];
        while (tcount < t0 + FRAME_T + 1) tick();
        chk("sim_cnt_before", {29'd0, fifo_cnt}, 32'd2);
        send(8'h64, acc[3], peak);
        chk("sim_acc", acc[3] - t0, FRAME_T + 1);
        chk("sim_cnt_after", {29'd0, fifo_cnt}, 32'd2);
        chk("sim_txd_start", {31'd0, txd}, 32'd0);
        drain(4, 1'b1);

        // Pointer wrap-around: 12 bytes through depth 4
        wait_idle();
        for (int i = 0; i < 12; i++) send(8'(i), acc[i], peak);
        drain(12, 1'b1);

        // Reset during DATA bit 3 with two bytes queued
        wait_idle();
        send(8'hA5, acc[0], peak);
        send(8'h11, acc[1], peak);
        send(8'h22, acc[2], peak);
        t0 = acc[0];
        while (tcount < t0 + 2 + 4 * BIT_T + 8) tick();
        chk("rst_mid_txd_pre", {31'd0, txd}, 32'd0);
        chk("rst_mid_cnt_pre", {29'd0, fifo_cnt}, 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_mid_txd",  {31'd0, txd},    32'd1);
        chk("rst_mid_cnt",  {29'd0, fifo_cnt}, 32'd0);
        chk("rst_mid_rdy",  {31'd0, rdy_tx}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy},   32'd0);
        exp_q.delete();
        tick(); tick();
        rstn = 1'b1;
        snap = rx_cnt;
        saw_low = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        chk("post_rst_quiet", {31'd0, saw_low}, 32'd0);
        chk("post_rst_frames", rx_cnt - snap, 0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        rd_idx = rx_cnt;
        send(8'h5A, acc[0], peak);
        drain(1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
